jk_seq_ctrl: RTL and testbench
==============================

Name: jk_seq_ctrl

Overview:
Command-driven controller that sequences a bank of WIDTH JK flip-flops by generating their J/K inputs each clock.
It supports four operations: load a value, clear, count up N times, and toggle a mask N times.
It reads the bank's Q outputs back to form counter equations.
It sits between a host/command source and a jk_ff bank clocked by the same clk.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank.
STEP_W, 8, width of the step-count field; max steps per command = 2^STEP_W-1.

Ports:
clk  input  1  system clock; bank is clocked on the same rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (high only in IDLE).
cmd_op  input  2  00 LOAD, 01 CLEAR, 10 COUNT, 11 TOGGLE.
cmd_arg  input  WIDTH  LOAD value, or TOGGLE mask; ignored otherwise.
cmd_steps  input  STEP_W  number of drive cycles for COUNT/TOGGLE; ignored for LOAD/CLEAR.
q_fb  input  WIDTH  Q outputs of the JK bank.
j_out  output  WIDTH  J inputs to the bank.
k_out  output  WIDTH  K inputs to the bank.
busy  output  1  high while in EXEC.
done  output  1  one-cycle pulse: command complete.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, j_out=k_out=0 (bank holds), busy=0, done=0, cmd_ready=1.
  - Step counter and latched op/arg cleared.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid&&cmd_ready.
  - op, arg and steps are latched on that edge.
  - cmd_valid outside IDLE is ignored; no queueing.
- States:
  - IDLE: j_out=k_out=0.
  - EXEC: drives the bank; remaining counter decrements each edge.
- Accept transitions:
  - LOAD/CLEAR: remaining=1 -> EXEC.
  - COUNT/TOGGLE with steps>0: remaining=steps -> EXEC.
  - COUNT/TOGGLE with steps==0: stay IDLE, done=1 next cycle, no drive cycle.
- EXEC drive (combinational from latched op/arg and q_fb):
  - LOAD: j=arg, k=~arg.
  - CLEAR: j=0, k=all ones.
  - COUNT: j[i]=k[i]=AND(q_fb[i-1:0]); bit 0 always toggles. This is a binary up-counter.
  - TOGGLE: j=k=arg.
- Completion: on the edge where remaining goes 1->0, state->IDLE and done=1 for exactly one cycle.
  - cmd_ready is high during the done cycle, so back-to-back commands have zero idle gap.
- Latency:
  - LOAD/CLEAR: bank updated on the first edge after accept; done visible the cycle after that.
  - COUNT/TOGGLE: bank updated on `steps` consecutive edges.
- Boundaries:
  - COUNT wraps modulo 2^WIDTH (all ones -> zero), with no flag.
  - TOGGLE mask 0 holds the bank for `steps` cycles.
  - steps = 2^STEP_W-1 must execute fully.
- busy=1 exactly in EXEC; done and busy are never both high.
- Reset mid-EXEC: aborts immediately. j/k go to 0 asynchronously, the bank freezes at its current Q, no done pulse. After release, IDLE with cmd_ready=1.
- All state is registered. j_out/k_out are combinational from registered state and q_fb; no combinational path from cmd_* to j/k.

Decomposition:
- Package jk_seq_pkg:
  - op-code constants OP_LOAD, OP_CLEAR, OP_COUNT, OP_TOGGLE.
  - state encoding ST_IDLE, ST_EXEC.
- Controller is a single module.
- Natural companion sub-module: jk_ff_bank. It instantiates WIDTH jk_ff cells with set/rst tied inactive and is used in the integration top and in the bench.

Test Plan:
- Reset: rst=1 -> j_out=k_out=0000, busy=0, done=0, cmd_ready=1.
- LOAD 1010 into jk_ff_bank: accept -> q=1010 after 1 edge; done pulse the following cycle; busy high 1 cycle.
- COUNT steps=7 from q=1010: busy 7 cycles; q = 1011,1100,...,0001 (17 mod 16); done once.
- CLEAR, then TOGGLE mask 0011 steps=3: q=0000 -> 0011 -> 0000 -> 0011; done.
  - Second command held valid during EXEC is accepted in the done cycle.
- COUNT steps=0 -> no drive, q unchanged, done on next cycle. COUNT from 1111 steps=1 -> q=0000 (wrap).
- rst asserted 3 cycles into COUNT steps=10: j/k=0 immediately, q frozen, no done; after release cmd_ready=1 and a LOAD works.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK bank sequencer: command op-codes and FSM states.
package jk_seq_pkg;

  // Host command op-codes, as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_COUNT  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  // Controller states: waiting for a command, or driving the bank.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage : jk_seq_pkg

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset and set (reset wins).
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;

  // Classic JK next-state: hold, reset, set, toggle.
  always_comb begin
    q_d = q;
    unique case ({j, k})
      2'b00:   q_d = q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q;
    endcase
  end

  // Storage element with asynchronous reset/set.
  always_ff @(posedge clk or posedge rst or posedge set) begin
    if (rst) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else begin
      q <= q_d;
    end
  end

endmodule : jk_ff

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops driven by the sequencer. The cells' set/reset
// are tied inactive so the bank only ever changes through its J/K inputs;
// in particular a controller reset leaves the bank holding its value.
module jk_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // One cell per bit, no shared control besides the clock.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff u_ff (
      .clk (clk),
      .rst (1'b0),
      .set (1'b0),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

endmodule : jk_ff_bank

// File: rtl/jk_seq_ctrl.sv
// Command-driven sequencer for a JK flip-flop bank: LOAD, CLEAR, COUNT N, TOGGLE N.
// J/K are derived combinationally from registered op/arg and the bank's Q
// feedback only, so there is no path from the command inputs to the bank.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_arg,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]  q_fb,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q,   rem_d;
  op_e               op_q,    op_d;
  logic [WIDTH-1:0]  arg_q,   arg_d;
  logic              done_q,  done_d;

  logic              count_carry;

  // Next-state: accept in IDLE, count down remaining drive cycles in EXEC.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    arg_d   = arg_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          arg_d = cmd_arg;
          unique case (op_e'(cmd_op))
            OP_LOAD, OP_CLEAR: begin
              rem_d   = STEP_W'(1);
              state_d = ST_EXEC;
            end
            default: begin
              // A zero-step COUNT/TOGGLE completes without ever driving the bank.
              if (cmd_steps == '0) begin
                rem_d  = '0;
                done_d = 1'b1;
              end else begin
                rem_d   = cmd_steps;
                state_d = ST_EXEC;
              end
            end
          endcase
        end
      end

      ST_EXEC: begin
        rem_d = rem_q - STEP_W'(1);
        if (rem_q == STEP_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      done_q  <= done_d;
    end
  end

  // Bank drive: zero (hold) outside EXEC, otherwise per latched op.
  always_comb begin
    j_out       = '0;
    k_out       = '0;
    count_carry = 1'b1;
    if (state_q == ST_EXEC) begin
      unique case (op_q)
        OP_LOAD: begin
          j_out = arg_q;
          k_out = ~arg_q;
        end
        OP_CLEAR: begin
          j_out = '0;
          k_out = '1;
        end
        OP_COUNT: begin
          // Ripple-carry up-counter: bit i toggles when all lower bits are 1.
          for (int i = 0; i < WIDTH; i++) begin
            j_out[i]    = count_carry;
            k_out[i]    = count_carry;
            count_carry = count_carry & q_fb[i];
          end
        end
        default: begin
          j_out = arg_q;
          k_out = arg_q;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EXEC);
  assign done      = done_q;

endmodule : jk_seq_ctrl

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl driving a real jk_ff_bank; a model predicts the bank
// value after every drive edge and a monitor compares it against the bank.
module tb_jk_seq_ctrl;
  import jk_seq_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_arg;
  logic [STEP_W-1:0] cmd_steps;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  j_out;
  logic [WIDTH-1:0]  k_out;
  logic              busy;
  logic              done;

  jk_seq_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_steps (cmd_steps),
    .q_fb      (q),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done)
  );

  jk_ff_bank #(.WIDTH(WIDTH)) bank (
    .clk (clk),
    .j   (j_out),
    .k   (k_out),
    .q   (q)
  );

  always #5 clk = ~clk;

  int               tests_run = 0;
  int               failed    = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_v;
  logic [WIDTH-1:0] model_q = '0;
  int               done_pend   = 0;
  int               busy_cycles = 0;
  int               done_seen   = 0;
  bit               mon_en      = 1'b0;
  bit               busy_prev   = 1'b0;
  bit               accepted_in_done = 1'b0;

  // Monitor: after every cycle that was busy the bank must show the next
  // predicted value; done pulses must match issued commands.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_prev) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL drive_extra: unexpected drive cycle, q=%b", q);
        end else begin
          exp_v = exp_q.pop_front();
          if (q !== exp_v) begin
            failed++;
            $display("FAIL bank_q: got %b expected %b", q, exp_v);
          end
        end
      end
      if (busy === 1'b1 && done === 1'b1) begin
        tests_run++;
        failed++;
        $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
      end
      if (done === 1'b1) begin
        tests_run++;
        done_seen++;
        if (done_pend == 0) begin
          failed++;
          $display("FAIL done_extra: done pulse with no pending command");
        end else begin
          done_pend--;
        end
      end
      if (busy === 1'b1) busy_cycles++;
      busy_prev = (busy === 1'b1);
    end else begin
      busy_prev = 1'b0;
    end
  end

  // Predict bank values for one accepted command.
  task automatic model_push(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                            input logic [STEP_W-1:0] steps);
    case (op)
      OP_LOAD:  begin model_q = arg; exp_q.push_back(model_q); end
      OP_CLEAR: begin model_q = '0;  exp_q.push_back(model_q); end
      OP_COUNT: begin
        for (int s = 0; s < int'(steps); s++) begin
          model_q = model_q + 1'b1;
          exp_q.push_back(model_q);
        end
      end
      default: begin
        for (int s = 0; s < int'(steps); s++) begin
          model_q = model_q ^ arg;
          exp_q.push_back(model_q);
        end
      end
    endcase
    done_pend++;
  endtask

  // Present a command, hold it until accepted, return 1 ns after the accept edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                      input logic [STEP_W-1:0] steps);
    int budget = 400;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_steps = steps;
    while (cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL accept_timeout: cmd_ready=%b expected 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      accepted_in_done = (done === 1'b1);
      model_push(op, arg, steps);
      @(posedge clk);
      #1;
      cmd_valid   = 1'b0;
      busy_cycles = 0;
      done_seen   = 0;
    end
  endtask

  // Wait until every predicted update and done pulse has been observed.
  task automatic wait_idle();
    int budget = 1000;
    while ((exp_q.size() != 0 || done_pend != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0 || done_pend != 0) begin
      failed++;
      $display("FAIL idle_timeout: pending updates=%0d pending done=%0d expected 0 0",
               exp_q.size(), done_pend);
    end
  endtask

  task automatic expect_bits(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] want);
    tests_run++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_arg   = '0;
    cmd_steps = '0;
    #3;
    expect_bits("reset_j", j_out, 4'b0000);
    expect_bits("reset_k", k_out, 4'b0000);
    expect_int("reset_busy", int'(busy), 0);
    expect_int("reset_done", int'(done), 0);
    expect_int("reset_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_load();
    send(OP_LOAD, 4'b1010, 8'd0);
    expect_int("load_busy_exec", int'(busy), 1);
    expect_int("load_done_early", int'(done), 0);
    expect_bits("load_j", j_out, 4'b1010);
    expect_bits("load_k", k_out, 4'b0101);
    @(posedge clk);
    #1;
    expect_bits("load_q", q, 4'b1010);
    expect_int("load_done_pulse", int'(done), 1);
    expect_int("load_busy_after", int'(busy), 0);
    wait_idle();
    expect_int("load_busy_cycles", busy_cycles, 1);
    expect_int("load_done_count", done_seen, 1);
  endtask

  task automatic test_count();
    send(OP_COUNT, 4'b0000, 8'd7);
    wait_idle();
    expect_int("count7_busy_cycles", busy_cycles, 7);
    expect_int("count7_done_count", done_seen, 1);
    expect_bits("count7_final_q", q, 4'b0001);
  endtask

  task automatic test_back_to_back();
    send(OP_CLEAR, 4'b1111, 8'd0);
    send(OP_TOGGLE, 4'b0011, 8'd3);
    expect_int("b2b_accept_in_done", int'(accepted_in_done), 1);
    wait_idle();
    expect_int("toggle_busy_cycles", busy_cycles, 3);
    expect_bits("toggle_final_q", q, 4'b0011);
    send(OP_TOGGLE, 4'b0000, 8'd4);
    wait_idle();
    expect_int("toggle0_busy_cycles", busy_cycles, 4);
    expect_bits("toggle0_hold_q", q, 4'b0011);
  endtask

  task automatic test_zero_and_wrap();
    send(OP_COUNT, 4'b0000, 8'd0);
    expect_int("zero_busy", int'(busy), 0);
    expect_int("zero_done", int'(done), 1);
    @(posedge clk);
    #1;
    expect_int("zero_done_single", int'(done), 0);
    expect_bits("zero_q_held", q, 4'b0011);
    wait_idle();
    send(OP_LOAD, 4'b1111, 8'd0);
    send(OP_COUNT, 4'b0000, 8'd1);
    wait_idle();
    expect_bits("wrap_q", q, 4'b0000);
  endtask

  task automatic test_max_steps();
    send(OP_COUNT, 4'b0000, 8'd255);
    wait_idle();
    expect_int("max_busy_cycles", busy_cycles, 255);
    expect_bits("max_final_q", q, 4'b1111);
  endtask

  task automatic test_reset_mid();
    send(OP_LOAD, 4'b0000, 8'd0);
    wait_idle();
    send(OP_COUNT, 4'b0000, 8'd10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    expect_bits("abort_j", j_out, 4'b0000);
    expect_bits("abort_k", k_out, 4'b0000);
    expect_int("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    expect_bits("abort_q_frozen", q, 4'b0011);
    expect_int("abort_no_done", int'(done), 0);
    exp_q.delete();
    done_pend = 0;
    model_q   = 4'b0011;
    rst       = 1'b0;
    #1;
    expect_int("abort_ready", int'(cmd_ready), 1);
    mon_en = 1'b1;
    send(OP_LOAD, 4'b0110, 8'd0);
    wait_idle();
    expect_bits("post_abort_load_q", q, 4'b0110);
  endtask

  initial begin
    test_reset();
    test_load();
    test_count();
    test_back_to_back();
    test_zero_and_wrap();
    test_max_steps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule : tb_jk_seq_ctrl
